fm_sb_capture: RTL and testbench
================================

// Module: fm_sb_capture
// PURPOSE
//  Capture stage feeding one fast-monitoring spy buffer. Taps a monitored L0MDT bus (fm_rt-style
//  data/valid), zero-pads each valid word to the AXI-aligned SB width and writes it into the
//  SB_MEM write port as a circular buffer. Supports arm/trigger/post-trigger freeze so software
//  can read a window around an event. One instance per SB index (0..sb_mapped_n-1).
// PARAMETERS
//  SB_TP_DW   51   tapped payload width (sb_tp_dw[i])
//  SB_DW      64   memory word width (sb_dw[i]); multiple of axi_dw; must be >= SB_TP_DW
//  ADDR_W     10   SB_MEM address width (axi_sb_addr_width[i]); depth = 2**ADDR_W
// PORTS
//  spy_clock        in   1        single clock for tap and write port
//  spy_reset_n      in   1        asynchronous active-low reset
//  tap_data         in   SB_TP_DW monitored bus data
//  tap_vld          in   1        monitored bus valid
//  pb_mode          in   2        00 spy, 01 playback (capture off), 10 trigger-freeze, 11 = 00
//  arm              in   1        pulse: clear status, start capture (mode 10 only)
//  trigger          in   1        pulse: start post-trigger countdown
//  post_trig_n      in   ADDR_W   words captured after trigger before freeze
//  mem_we           out  1        SB_MEM write enable
//  mem_addr         out  ADDR_W   SB_MEM write address
//  mem_wdata        out  SB_DW    {zero pad, tap_data}
//  wr_ptr           out  ADDR_W   next address to be written
//  trig_addr        out  ADDR_W   address written on trigger cycle (or next write if none)
//  wrapped          out  1        sticky: pointer wrapped since arm/reset
//  frozen           out  1        capture halted after post-trigger window
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; wr_ptr=0.
//  - Latency: tap_vld at cycle N -> mem_we=1 at N+1 with registered addr/data. No backpressure;
//    capture never stalls the monitored bus.
//  - FSM: IDLE -> (mode 00) SPY | (mode 10 & arm) ARMED. SPY: write every valid word, wrap freely.
//    ARMED: write every valid; trigger -> POST with cnt=post_trig_n, trig_addr latched.
//    POST: each write decrements cnt; write taking cnt to 0 (or cnt==0 on entry) -> FROZEN.
//    FROZEN: mem_we=0, frozen=1, pointers hold; arm -> ARMED (clears frozen/wrapped, keeps wr_ptr).
//  - pb_mode change: any state -> IDLE next cycle, mem_we forced 0; mode 01 leaves mem untouched.
//  - Trigger with no tap_vld same cycle: trig_addr = wr_ptr (next write). With tap_vld: the address
//    of that word. Trigger outside ARMED ignored. Repeated trigger in POST ignored.
//  - arm and trigger same cycle in FROZEN/IDLE: arm wins, trigger ignored.
//  - Wrap: wr_ptr increments mod 2**ADDR_W; wrapped set on transition max->0, sticky.
//  - post_trig_n sampled on trigger cycle only. post_trig_n=0 freezes immediately after trigger word.
//  - Reset mid-capture: immediate return to reset values; memory contents not cleared.
// STRUCTURE
//  - fm_sb_pkg: capture state enum (fm_sb_cap_state_t), pb_mode encodings as named constants.
//  - Single module, no sub-modules; pad/pack is a continuous assign. Wrapper generate loop over
//    sb_mapped_n instantiates with sb_tp_dw/sb_dw/axi_sb_addr_width.
// TESTING
//  1 Reset: spy_reset_n low mid-stream -> all outputs 0 same cycle asynchronously; wr_ptr=0.
//  2 Spy mode, ADDR_W=4, 20 valid words 0..19 -> addrs 0..15,0..3; wrapped=1 after word 16.
//  3 Mode 10, arm, 5 words, trigger on word 5 (post_trig_n=3) -> trig_addr=5, words 6..8
//    written, frozen=1, word 9 not written, wr_ptr=9.
//  4 post_trig_n=0, trigger with tap_vld -> that word written, frozen next cycle, no further writes.
//  5 Mode 01 with tap_vld toggling -> mem_we never asserted; switch to 00 -> writes resume at wr_ptr.
//  6 Padding: SB_TP_DW=51, SB_DW=64, tap_data all ones -> mem_wdata[63:51]=0, [50:0] all ones.

Source files
------------

// File: rtl/fm_sb_pkg.sv
// Shared types for the fast-monitoring spy-buffer capture stage.
// Holds the capture FSM encoding and the pb_mode encodings.
package fm_sb_pkg;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_SPY,
        CAP_ARMED,
        CAP_POST,
        CAP_FROZEN
    } fm_sb_cap_state_t;

    localparam logic [1:0] PB_SPY     = 2'b00;
    localparam logic [1:0] PB_PLAY    = 2'b01;
    localparam logic [1:0] PB_TRIG    = 2'b10;
    localparam logic [1:0] PB_SPY_ALT = 2'b11;

    // 11 behaves exactly like 00, so fold it before comparing modes.
    function automatic logic [1:0] pb_norm(input logic [1:0] m);
        return (m == PB_SPY_ALT) ? PB_SPY : m;
    endfunction

endpackage

// File: rtl/fm_sb_capture.sv
// Spy-buffer capture stage: taps a monitored bus and writes padded words
// into SB_MEM as a circular buffer with arm/trigger/post-trigger freeze.
// Ports:
//   spy_clock, spy_reset_n        clock, async active-low reset
//   tap_data, tap_vld             monitored bus
//   pb_mode, arm, trigger         control (pb_mode 00/11 spy, 01 off, 10 trig)
//   post_trig_n                   words kept after trigger (sampled on trigger)
//   mem_we, mem_addr, mem_wdata   SB_MEM write port (1-cycle latency)
//   wr_ptr, trig_addr             next write address, trigger address
//   wrapped, frozen               sticky wrap flag, capture halted
module fm_sb_capture
    import fm_sb_pkg::*;
#(
    parameter int SB_TP_DW = 51,
    parameter int SB_DW    = 64,
    parameter int ADDR_W   = 10
) (
    input  logic                spy_clock,
    input  logic                spy_reset_n,
    input  logic [SB_TP_DW-1:0] tap_data,
    input  logic                tap_vld,
    input  logic [1:0]          pb_mode,
    input  logic                arm,
    input  logic                trigger,
    input  logic [ADDR_W-1:0]   post_trig_n,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [SB_DW-1:0]    mem_wdata,
    output logic [ADDR_W-1:0]   wr_ptr,
    output logic [ADDR_W-1:0]   trig_addr,
    output logic                wrapped,
    output logic                frozen
);

    fm_sb_cap_state_t    state_q, state_d;
    logic [1:0]          mode_q;
    logic [1:0]          mode_n;
    logic                mode_chg;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   trig_addr_q;
    logic                wrapped_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [SB_DW-1:0]    mem_wdata_q;
    logic [SB_DW-1:0]    pad_data;
    logic                cap;
    logic                arm_hit;
    logic                trig_hit;

    assign pad_data = SB_DW'(tap_data);
    assign mode_n   = pb_norm(pb_mode);
    assign mode_chg = (mode_n != mode_q);

    // State register
    always_ff @(posedge spy_clock or negedge spy_reset_n) begin
        if (!spy_reset_n) begin
            state_q <= CAP_IDLE;
            mode_q  <= PB_SPY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_n;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap      = 1'b0;
        arm_hit  = 1'b0;
        trig_hit = 1'b0;
        if (mode_chg) begin
            // Any mode change parks the FSM and suppresses this cycle's write.
            state_d = CAP_IDLE;
        end else begin
            unique case (state_q)
                CAP_IDLE: begin
                    if (mode_n == PB_SPY) begin
                        state_d = CAP_SPY;
                    end else if (mode_n == PB_TRIG && arm) begin
                        state_d = CAP_ARMED;
                        arm_hit = 1'b1;
                    end
                end
                CAP_SPY: begin
                    cap = tap_vld;
                end
                CAP_ARMED: begin
                    cap = tap_vld;
                    if (arm) begin
                        arm_hit = 1'b1;
                    end else if (trigger) begin
                        trig_hit = 1'b1;
                        // The trigger word itself is not part of the window.
                        if (post_trig_n == '0) begin
                            state_d = CAP_FROZEN;
                        end else begin
                            state_d = CAP_POST;
                            cnt_d   = post_trig_n;
                        end
                    end
                end
                CAP_POST: begin
                    cap = tap_vld;
                    if (arm) begin
                        arm_hit = 1'b1;
                        state_d = CAP_ARMED;
                    end else if (tap_vld) begin
                        cnt_d = cnt_q - ADDR_W'(1);
                        if (cnt_q == ADDR_W'(1)) begin
                            state_d = CAP_FROZEN;
                        end
                    end
                end
                CAP_FROZEN: begin
                    if (arm) begin
                        arm_hit = 1'b1;
                        state_d = CAP_ARMED;
                    end
                end
                default: state_d = CAP_IDLE;
            endcase
        end
    end

    // Write port and status registers
    always_ff @(posedge spy_clock or negedge spy_reset_n) begin
        if (!spy_reset_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            wrapped_q   <= 1'b0;
        end else begin
            mem_we_q <= cap;
            if (cap) begin
                mem_addr_q  <= wr_ptr_q;
                mem_wdata_q <= pad_data;
                wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
            end
            if (trig_hit) begin
                trig_addr_q <= wr_ptr_q;
            end
            if (arm_hit) begin
                wrapped_q <= 1'b0;
            end
            if (cap && wr_ptr_q == '1) begin
                wrapped_q <= 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        wr_ptr    = wr_ptr_q;
        trig_addr = trig_addr_q;
        wrapped   = wrapped_q;
        frozen    = (state_q == CAP_FROZEN);
    end

endmodule

// File: tb/tb_fm_sb_capture.sv
// Self-checking bench for fm_sb_capture.
// Scoreboard of expected writes, popped as SB_MEM writes appear.
module tb_fm_sb_capture;

    localparam int TP = 51;
    localparam int DW = 64;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [TP-1:0] tap_data = '0;
    logic          tap_vld = 1'b0;
    logic [1:0]    pb_mode = 2'b00;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic [AW-1:0] post_trig_n = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] trig_addr;
    logic          wrapped;
    logic          frozen;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           sb_q[$];
    wr_t           mon_e;
    logic [AW-1:0] exp_ptr;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    fm_sb_capture #(
        .SB_TP_DW(TP),
        .SB_DW   (DW),
        .ADDR_W  (AW)
    ) dut (
        .spy_clock  (clk),
        .spy_reset_n(rst_n),
        .tap_data   (tap_data),
        .tap_vld    (tap_vld),
        .pb_mode    (pb_mode),
        .arm        (arm),
        .trigger    (trigger),
        .post_trig_n(post_trig_n),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .wr_ptr     (wr_ptr),
        .trig_addr  (trig_addr),
        .wrapped    (wrapped),
        .frozen     (frozen)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we !== 1'b0) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got we=%b addr=%0d data=%h, expected no write",
                         mem_we, mem_addr, mem_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr, mem_wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [TP-1:0] d,
                        input logic a, input logic t, input logic cap);
        wr_t w;
        tap_vld  = v;
        tap_data = d;
        arm      = a;
        trigger  = t;
        if (cap) begin
            w.a = exp_ptr;
            w.d = {{(DW-TP){1'b0}}, d};
            sb_q.push_back(w);
            exp_ptr = exp_ptr + 1'b1;
        end
        @(posedge clk);
        #1;
        tap_vld = 1'b0;
        arm     = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic [1:0] mode);
        rst_n       = 1'b0;
        pb_mode     = mode;
        tap_vld     = 1'b0;
        arm         = 1'b0;
        trigger     = 1'b0;
        post_trig_n = '0;
        @(posedge clk);
        #1;
        sb_q.delete();
        exp_ptr = '0;
        rst_n   = 1'b1;
        idle(2);
    endtask

    task automatic drain(input string name);
        idle(3);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL %s_missing_writes: got %0d pending, expected 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({mem_we, mem_addr, mem_wdata, wr_ptr, trig_addr, wrapped, frozen} !== '0) begin
            fails++;
            $display("FAIL reset_init: got we=%b ptr=%0d wrapped=%b frozen=%b, expected all 0",
                     mem_we, wr_ptr, wrapped, frozen);
        end
        do_reset(2'b00);
        for (int i = 0; i < 3; i++) step(1'b1, TP'(i + 100), 1'b0, 1'b0, 1'b1);
        tests++;
        if (mem_we !== 1'b1 || wr_ptr !== AW'(3)) begin
            fails++;
            $display("FAIL reset_prestream: got we=%b ptr=%0d, expected we=1 ptr=3", mem_we, wr_ptr);
        end
        tap_vld = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({mem_we, mem_addr, mem_wdata, wr_ptr, trig_addr, wrapped, frozen} !== '0) begin
            fails++;
            $display("FAIL reset_async: got we=%b addr=%0d ptr=%0d, expected all 0",
                     mem_we, mem_addr, wr_ptr);
        end
        do_reset(2'b00);
    endtask

    task automatic test_spy_wrap();
        do_reset(2'b00);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, TP'(i), 1'b0, (i == 7), 1'b1);
            if (i == 14) begin
                tests++;
                if (wrapped !== 1'b0) begin
                    fails++;
                    $display("FAIL spy_wrap_early: got %b, expected 0", wrapped);
                end
            end
            if (i == 15) begin
                tests++;
                if (wrapped !== 1'b1) begin
                    fails++;
                    $display("FAIL spy_wrap_set: got %b, expected 1", wrapped);
                end
            end
        end
        drain("spy");
        tests++;
        if (wr_ptr !== AW'(4) || wrapped !== 1'b1 || trig_addr !== AW'(0)) begin
            fails++;
            $display("FAIL spy_end: got ptr=%0d wrapped=%b trig=%0d, expected 4 1 0",
                     wr_ptr, wrapped, trig_addr);
        end
    endtask

    task automatic test_trig_window();
        do_reset(2'b10);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, TP'(i), 1'b0, 1'b0, 1'b1);
        post_trig_n = AW'(3);
        step(1'b1, TP'(5), 1'b0, 1'b1, 1'b1);
        post_trig_n = AW'(7);
        tests++;
        if (trig_addr !== AW'(5) || frozen !== 1'b0) begin
            fails++;
            $display("FAIL trig_latch: got trig=%0d frozen=%b, expected 5 0", trig_addr, frozen);
        end
        step(1'b1, TP'(6), 1'b0, 1'b0, 1'b1);
        step(1'b1, TP'(7), 1'b0, 1'b0, 1'b1);
        tests++;
        if (frozen !== 1'b0) begin
            fails++;
            $display("FAIL trig_early_freeze: got %b, expected 0", frozen);
        end
        step(1'b1, TP'(8), 1'b0, 1'b0, 1'b1);
        tests++;
        if (frozen !== 1'b1) begin
            fails++;
            $display("FAIL trig_freeze: got %b, expected 1", frozen);
        end
        for (int i = 9; i < 12; i++) step(1'b1, TP'(i), 1'b0, 1'b1, 1'b0);
        drain("trig");
        tests++;
        if (wr_ptr !== AW'(9) || frozen !== 1'b1 || trig_addr !== AW'(5)) begin
            fails++;
            $display("FAIL trig_hold: got ptr=%0d frozen=%b trig=%0d, expected 9 1 5",
                     wr_ptr, frozen, trig_addr);
        end
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tests++;
        if (frozen !== 1'b0 || trig_addr !== AW'(5)) begin
            fails++;
            $display("FAIL rearm: got frozen=%b trig=%0d, expected 0 5", frozen, trig_addr);
        end
        step(1'b1, TP'(12), 1'b0, 1'b0, 1'b1);
        step(1'b1, TP'(13), 1'b0, 1'b0, 1'b1);
        post_trig_n = AW'(1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (trig_addr !== AW'(11)) begin
            fails++;
            $display("FAIL trig_novld: got %0d, expected 11", trig_addr);
        end
        step(1'b1, TP'(14), 1'b0, 1'b0, 1'b1);
        step(1'b1, TP'(15), 1'b0, 1'b0, 1'b0);
        drain("rearm");
        tests++;
        if (frozen !== 1'b1 || wr_ptr !== AW'(12)) begin
            fails++;
            $display("FAIL rearm_freeze: got frozen=%b ptr=%0d, expected 1 12", frozen, wr_ptr);
        end
    endtask

    task automatic test_post_zero();
        do_reset(2'b10);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, TP'(40), 1'b0, 1'b0, 1'b1);
        step(1'b1, TP'(41), 1'b0, 1'b0, 1'b1);
        post_trig_n = '0;
        step(1'b1, TP'(42), 1'b0, 1'b1, 1'b1);
        tests++;
        if (frozen !== 1'b1 || mem_we !== 1'b1 || trig_addr !== AW'(2)) begin
            fails++;
            $display("FAIL pz_freeze: got frozen=%b we=%b trig=%0d, expected 1 1 2",
                     frozen, mem_we, trig_addr);
        end
        for (int i = 0; i < 3; i++) step(1'b1, TP'(50 + i), 1'b0, 1'b0, 1'b0);
        drain("pz");
        tests++;
        if (wr_ptr !== AW'(3)) begin
            fails++;
            $display("FAIL pz_ptr: got %0d, expected 3", wr_ptr);
        end
    endtask

    task automatic test_playback();
        do_reset(2'b00);
        for (int i = 0; i < 3; i++) step(1'b1, TP'(60 + i), 1'b0, 1'b0, 1'b1);
        pb_mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            step(i[0], TP'(70 + i), 1'b0, 1'b0, 1'b0);
            tests++;
            if (mem_we !== 1'b0) begin
                fails++;
                $display("FAIL pb_we: got %b, expected 0", mem_we);
            end
        end
        tests++;
        if (wr_ptr !== AW'(3)) begin
            fails++;
            $display("FAIL pb_ptr_hold: got %0d, expected 3", wr_ptr);
        end
        pb_mode = 2'b00;
        step(1'b1, TP'(80), 1'b0, 1'b0, 1'b0);
        step(1'b1, TP'(81), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, TP'(90 + i), 1'b0, 1'b0, 1'b1);
        drain("pb");
        tests++;
        if (wr_ptr !== AW'(6)) begin
            fails++;
            $display("FAIL pb_resume: got %0d, expected 6", wr_ptr);
        end
    endtask

    task automatic test_padding();
        logic [TP-1:0] ones;
        logic [TP-1:0] alt;
        ones = '1;
        alt  = {26{2'b10}};
        do_reset(2'b00);
        step(1'b1, ones, 1'b0, 1'b0, 1'b1);
        tests++;
        if (mem_wdata[DW-1:TP] !== '0 || mem_wdata[TP-1:0] !== ones) begin
            fails++;
            $display("FAIL pad_ones: got %h, expected %h", mem_wdata, {13'h0, ones});
        end
        step(1'b1, alt, 1'b0, 1'b0, 1'b1);
        drain("pad");
    endtask

    initial begin
        test_reset();
        test_spy_wrap();
        test_trig_window();
        test_post_zero();
        test_playback();
        test_padding();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
